if_fetch_stage: RTL and testbench

//  Instruction-fetch stage sitting directly upstream of the instruction ROM. Holds the PC,

---
 rtl/if_fetch_stage_if.sv | 36 +++
 rtl/if_fetch_stage.sv | 93 +++++++++
 tb/tb_if_fetch_stage.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_stage_if.sv
// Instruction-fetch stage bus bundle.
// Groups the hazard/redirect inputs, the instruction-ROM port and the IF/ID
// pipeline register outputs of if_fetch_stage.
//   master : the fetch stage (drives ROM address/enable and IF/ID)
//   slave  : surrounding pipeline and ROM (drives stall, redirects, ROM data)
// Signals:
//   stall, branch_taken, branch_target, jump, jump_index  -> fetch stage
//   imem_instr                                            -> fetch stage
//   imem_en, pc                                           -> ROM
//   ifid_instr, ifid_pc4, ifid_valid, fetch_count         -> decode / status
interface if_fetch_stage_if #(
    parameter int CNT_W = 32
);
    logic             stall;
    logic             branch_taken;
    logic [31:0]      branch_target;
    logic             jump;
    logic [25:0]      jump_index;
    logic             imem_en;
    logic [31:0]      pc;
    logic [31:0]      imem_instr;
    logic [31:0]      ifid_instr;
    logic [31:0]      ifid_pc4;
    logic             ifid_valid;
    logic [CNT_W-1:0] fetch_count;

    modport master (
        input  stall, branch_taken, branch_target, jump, jump_index, imem_instr,
        output imem_en, pc, ifid_instr, ifid_pc4, ifid_valid, fetch_count
    );

    modport slave (
        output stall, branch_taken, branch_target, jump, jump_index, imem_instr,
        input  imem_en, pc, ifid_instr, ifid_pc4, ifid_valid, fetch_count
    );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage in front of the instruction ROM.
// Holds the PC, presents it to the ROM together with the ROM enable, and loads
// the returned word plus PC+4 into the IF/ID register. EX branch redirects win
// over ID jump redirects, and both win over a hazard stall. Counts valid IF/ID
// loads with a saturating counter.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    if_fetch_stage_if.master (redirects, stall, ROM port, IF/ID outputs)
//
// state | meaning
// WARM  | first cycle after reset release: enable ROM, hold PC and IF/ID
// RUN   | normal fetch with branch > jump > stall priority
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    if_fetch_stage_if.master  bus
);
    typedef enum logic {WARM, RUN} state_t;

    state_t           state;
    logic             imem_en_q;
    logic [31:0]      pc_q;
    logic [31:0]      ifid_instr_q;
    logic [31:0]      ifid_pc4_q;
    logic             ifid_valid_q;
    logic [CNT_W-1:0] cnt_q;

    logic [31:0]      pc_plus4;
    logic [31:0]      branch_pc;
    logic [31:0]      jump_pc;
    logic [CNT_W-1:0] cnt_one;
    logic             unused_target_lsb;

    assign pc_plus4  = pc_q + 32'd4;
    assign branch_pc = {bus.branch_target[31:2], 2'b00};
    // Jump region comes from the j instruction's own PC+4, which sits in IF/ID.
    assign jump_pc   = {ifid_pc4_q[31:28], bus.jump_index, 2'b00};
    assign cnt_one   = {{(CNT_W-1){1'b0}}, 1'b1};
    assign unused_target_lsb = ^bus.branch_target[1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= WARM;
            imem_en_q    <= 1'b0;
            pc_q         <= RESET_PC;
            ifid_instr_q <= NOP;
            ifid_pc4_q   <= 32'h0;
            ifid_valid_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            case (state)
                WARM: begin
                    imem_en_q <= 1'b1;
                    state     <= RUN;
                end
                RUN: begin
                    if (bus.branch_taken) begin
                        pc_q         <= branch_pc;
                        ifid_instr_q <= NOP;
                        ifid_pc4_q   <= 32'h0;
                        ifid_valid_q <= 1'b0;
                    end else if (bus.jump) begin
                        pc_q         <= jump_pc;
                        ifid_instr_q <= NOP;
                        ifid_pc4_q   <= 32'h0;
                        ifid_valid_q <= 1'b0;
                    end else if (!bus.stall) begin
                        pc_q         <= pc_plus4;
                        ifid_instr_q <= bus.imem_instr;
                        ifid_pc4_q   <= pc_plus4;
                        ifid_valid_q <= 1'b1;
                        if (cnt_q != {CNT_W{1'b1}}) begin
                            cnt_q <= cnt_q + cnt_one;
                        end
                    end
                end
                default: state <= WARM;
            endcase
        end
    end

    assign bus.imem_en     = imem_en_q;
    assign bus.pc          = pc_q;
    assign bus.ifid_instr  = ifid_instr_q;
    assign bus.ifid_pc4    = ifid_pc4_q;
    assign bus.ifid_valid  = ifid_valid_q;
    assign bus.fetch_count = cnt_q;
endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;
    logic clk;
    logic rst_n;
    logic rst_s;

    if_fetch_stage_if #(.CNT_W(32)) bus_m ();
    if_fetch_stage_if #(.CNT_W(4))  bus_s ();

    if_fetch_stage #(.CNT_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_m)
    );

    if_fetch_stage #(.CNT_W(4)) dut_sat (
        .clk   (clk),
        .rst_n (rst_s),
        .bus   (bus_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [3:0] idx);
        return {16'hC0DE, 12'h000, idx};
    endfunction

    // Combinational ROM model: returns 0 while disabled.
    always_comb begin
        bus_m.imem_instr = bus_m.imem_en ? rom_word(bus_m.pc[5:2]) : 32'h0;
        bus_s.imem_instr = bus_s.imem_en ? rom_word(bus_s.pc[5:2]) : 32'h0;
    end

    typedef struct {
        logic        st;
        logic        br;
        logic [31:0] bt;
        logic        jp;
        logic [25:0] ji;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic [31:0] e_pc4;
        logic        chk_pc4;
        logic        e_valid;
        logic [31:0] e_cnt;
    } vec_t;

    typedef struct {
        int          idx;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        chk_pc4;
        logic        valid;
        logic [31:0] cnt;
    } exp_t;

    localparam int NV = 23;
    vec_t vecs [NV];
    exp_t sb_q [$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic st, input logic br, input logic [31:0] bt,
                                input logic jp, input logic [25:0] ji,
                                input logic [31:0] e_pc, input logic [31:0] e_instr,
                                input logic [31:0] e_pc4, input logic chk_pc4,
                                input logic e_valid, input logic [31:0] e_cnt);
        vec_t v;
        v.st = st; v.br = br; v.bt = bt; v.jp = jp; v.ji = ji;
        v.e_pc = e_pc; v.e_instr = e_instr; v.e_pc4 = e_pc4; v.chk_pc4 = chk_pc4;
        v.e_valid = e_valid; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic drive_idle();
        bus_m.stall = 1'b0; bus_m.branch_taken = 1'b0; bus_m.branch_target = 32'h0;
        bus_m.jump = 1'b0; bus_m.jump_index = 26'h0;
    endtask

    task automatic chk_reset_main(input string tag);
        chk({tag, " imem_en"},    {31'h0, bus_m.imem_en},    32'h0);
        chk({tag, " pc"},         bus_m.pc,                  32'h0);
        chk({tag, " ifid_instr"}, bus_m.ifid_instr,          32'h0);
        chk({tag, " ifid_pc4"},   bus_m.ifid_pc4,            32'h0);
        chk({tag, " ifid_valid"}, {31'h0, bus_m.ifid_valid}, 32'h0);
        chk({tag, " fetch_count"}, bus_m.fetch_count,        32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        //              st br bt            jp ji            pc            instr         pc4           c  v  cnt
        vecs[0]  = mk(0, 0, 32'h0,        0, 26'h0,       32'h0000_0000, 32'h0,        32'h0,        1, 0, 0);
        vecs[1]  = mk(0, 0, 32'h0,        0, 26'h0,       32'h0000_0004, rom_word(0),  32'h4,        1, 1, 1);
        vecs[2]  = mk(0, 0, 32'h0,        0, 26'h0,       32'h0000_0008, rom_word(1),  32'h8,        1, 1, 2);
        vecs[3]  = mk(0, 0, 32'h0,        0, 26'h0,       32'h0000_000C, rom_word(2),  32'hC,        1, 1, 3);
        vecs[4]  = mk(1, 0, 32'h0,        0, 26'h0,       32'h0000_000C, rom_word(2),  32'hC,        1, 1, 3);
        vecs[5]  = mk(1, 0, 32'h0,        0, 26'h0,       32'h0000_000C, rom_word(2),  32'hC,        1, 1, 3);
        vecs[6]  = mk(1, 0, 32'h0,        0, 26'h0,       32'h0000_000C, rom_word(2),  32'hC,        1, 1, 3);
        vecs[7]  = mk(0, 0, 32'h0,        0, 26'h0,       32'h0000_0010, rom_word(3),  32'h10,       1, 1, 4);
        vecs[8]  = mk(0, 0, 32'h0,        0, 26'h0,       32'h0000_0014, rom_word(4),  32'h14,       1, 1, 5);
        vecs[9]  = mk(0, 1, 32'h3B,       0, 26'h0,       32'h0000_0038, 32'h0,        32'h0,        0, 0, 5);
        vecs[10] = mk(0, 0, 32'h0,        0, 26'h0,       32'h0000_003C, rom_word(14), 32'h3C,       1, 1, 6);
        vecs[11] = mk(0, 0, 32'h0,        0, 26'h0,       32'h0000_0040, rom_word(15), 32'h40,       1, 1, 7);
        vecs[12] = mk(0, 0, 32'h0,        1, 26'h4,       32'h0000_0010, 32'h0,        32'h0,        0, 0, 7);
        vecs[13] = mk(0, 0, 32'h0,        0, 26'h0,       32'h0000_0014, rom_word(4),  32'h14,       1, 1, 8);
        vecs[14] = mk(1, 1, 32'h20,       1, 26'h2A,      32'h0000_0020, 32'h0,        32'h0,        0, 0, 8);
        vecs[15] = mk(1, 0, 32'h0,        0, 26'h0,       32'h0000_0020, 32'h0,        32'h0,        0, 0, 8);
        vecs[16] = mk(0, 0, 32'h0,        0, 26'h0,       32'h0000_0024, rom_word(8),  32'h24,       1, 1, 9);
        vecs[17] = mk(1, 0, 32'h0,        1, 26'h3FF_FFFF, 32'h0FFF_FFFC, 32'h0,       32'h0,        0, 0, 9);
        vecs[18] = mk(0, 0, 32'h0,        0, 26'h0,       32'h1000_0000, rom_word(15), 32'h1000_0000, 1, 1, 10);
        vecs[19] = mk(0, 0, 32'h0,        1, 26'h1,       32'h1000_0004, 32'h0,        32'h0,        0, 0, 10);
        vecs[20] = mk(0, 1, 32'hFFFF_FFFF, 0, 26'h0,      32'hFFFF_FFFC, 32'h0,        32'h0,        0, 0, 10);
        vecs[21] = mk(0, 0, 32'h0,        0, 26'h0,       32'h0000_0000, rom_word(15), 32'h0,        1, 1, 11);
        vecs[22] = mk(0, 0, 32'h0,        0, 26'h0,       32'h0000_0004, rom_word(0),  32'h4,        1, 1, 12);

        rst_n = 1'b0;
        rst_s = 1'b0;
        drive_idle();
        bus_s.stall = 1'b0; bus_s.branch_taken = 1'b0; bus_s.branch_target = 32'h0;
        bus_s.jump = 1'b0; bus_s.jump_index = 26'h0;

        repeat (2) @(posedge clk);
        #1;
        chk_reset_main("reset");

        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            exp_t e;
            bus_m.stall         = vecs[i].st;
            bus_m.branch_taken  = vecs[i].br;
            bus_m.branch_target = vecs[i].bt;
            bus_m.jump          = vecs[i].jp;
            bus_m.jump_index    = vecs[i].ji;
            e.idx = i; e.pc = vecs[i].e_pc; e.instr = vecs[i].e_instr; e.pc4 = vecs[i].e_pc4;
            e.chk_pc4 = vecs[i].chk_pc4; e.valid = vecs[i].e_valid; e.cnt = vecs[i].e_cnt;
            sb_q.push_back(e);
            @(posedge clk);
            #1;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard: queue empty at vector %0d", i);
            end else begin
                exp_t x;
                x = sb_q.pop_front();
                chk($sformatf("v%0d imem_en", x.idx), {31'h0, bus_m.imem_en}, 32'h1);
                chk($sformatf("v%0d pc", x.idx), bus_m.pc, x.pc);
                chk($sformatf("v%0d ifid_instr", x.idx), bus_m.ifid_instr, x.instr);
                if (x.chk_pc4)
                    chk($sformatf("v%0d ifid_pc4", x.idx), bus_m.ifid_pc4, x.pc4);
                chk($sformatf("v%0d ifid_valid", x.idx), {31'h0, bus_m.ifid_valid}, {31'h0, x.valid});
                chk($sformatf("v%0d fetch_count", x.idx), bus_m.fetch_count, x.cnt);
            end
        end
        drive_idle();

        // Saturating counter on the 4-bit instance.
        @(negedge clk);
        rst_s = 1'b1;
        @(posedge clk);
        #1;
        chk("sat warm imem_en", {31'h0, bus_s.imem_en}, 32'h1);
        chk("sat warm count", {28'h0, bus_s.fetch_count}, 32'h0);
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (k == 14) chk("sat count 14", {28'h0, bus_s.fetch_count}, 32'hE);
            if (k == 15) chk("sat count 15", {28'h0, bus_s.fetch_count}, 32'hF);
            if (k == 20) chk("sat count 20", {28'h0, bus_s.fetch_count}, 32'hF);
        end
        chk("sat pc after 20", bus_s.pc, 32'h50);

        // Asynchronous reset mid-cycle, checked before the next edge.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        rst_s = 1'b0;
        #1;
        chk_reset_main("async");
        chk("async sat count", {28'h0, bus_s.fetch_count}, 32'h0);
        chk("async sat pc", bus_s.pc, 32'h0);

        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rewarm imem_en", {31'h0, bus_m.imem_en}, 32'h1);
        chk("rewarm pc", bus_m.pc, 32'h0);
        chk("rewarm valid", {31'h0, bus_m.ifid_valid}, 32'h0);
        @(posedge clk);
        #1;
        chk("rerun pc", bus_m.pc, 32'h4);
        chk("rerun instr", bus_m.ifid_instr, rom_word(0));
        chk("rerun count", bus_m.fetch_count, 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
